dma_cg_ctrl: RTL and testbench
==============================

DMA_CG_CTRL -- requirements
Module: dma_cg_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8: width of idle_thresh and of the idle counter.
REQ-002 Parameter WAKE_CYC, default 2, legal range 1..15: settle cycles between re-enabling the clock and acknowledging wake.
REQ-003 Parameter EVT_W, default 16: width of gate_events.
REQ-004 clk  in  1  free-running (ungated) clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cg_enable  in  1  software enable of automatic gating.
REQ-007 test_mode  in  1  scan/test; holds the block in RUN.
REQ-008 busy  in  1  downstream channel activity; high = clock needed.
REQ-009 wake_req  in  1  level request to restore the gated clock; held until wake_ack.
REQ-010 idle_thresh  in  IDLE_W  consecutive idle cycles before gating; 0 disables gating.
REQ-011 clk_en  out  1  registered enable to the v_cg clock-gate cell.
REQ-012 wake_ack  out  1  one-cycle pulse completing a wake_req.
REQ-013 gated  out  1  registered status; high exactly while in GATED.
REQ-014 gate_events  out  EVT_W  saturating count of entries into GATED.

Function
REQ-015 Four states SHALL exist: RUN, IDLE_CNT, GATED, WAKE. Define idle = cg_enable & ~busy & ~wake_req & ~test_mode & (idle_thresh != 0).
REQ-016 RUN: clk_en=1. If idle, go to IDLE_CNT with counter=1. Otherwise remain.
REQ-017 IDLE_CNT: clk_en=1. If ~idle, go to RUN and clear counter. Else if counter == idle_thresh, go to GATED. Else increment counter.
REQ-018 Net effect: after idle_thresh consecutive idle cycles in RUN/IDLE_CNT, clk_en SHALL be 0 from the next cycle. Example: idle_thresh=3, idle from cycle 0 gives clk_en=0 at cycle 4.
REQ-019 The counter SHALL never wrap. idle_thresh changing mid-count SHALL take effect immediately via the equality compare. If the counter already exceeds the new threshold, go to GATED on the next cycle.
REQ-020 GATED: clk_en=0, gated=1. If busy, wake_req, ~cg_enable or test_mode is high, go to WAKE; clk_en=1 from the following cycle.
REQ-021 WAKE: clk_en=1. Stay exactly WAKE_CYC cycles, then go to RUN. If wake_req is high on the last WAKE cycle, pulse wake_ack on the first RUN cycle.
REQ-022 wake_req high while in RUN or IDLE_CNT SHALL produce wake_ack in the next cycle, with no gating in between.
REQ-023 wake_req SHALL be ignored in the cycle after wake_ack. One request yields exactly one pulse.
REQ-024 wake_req dropping during WAKE SHALL NOT abort WAKE. No wake_ack is issued in that case.
REQ-025 gate_events SHALL increment on each IDLE_CNT->GATED transition and saturate at all-ones.
REQ-026 test_mode high SHALL force the next state to RUN from any state except GATED, which goes through WAKE per REQ-020. The counter SHALL be held at 0.
REQ-027 Simultaneous busy and wake_req in GATED: a single WAKE sequence, one wake_ack.
REQ-028 clk_en SHALL never be 0 for fewer than 1 cycle, and it SHALL never be 0 while the state is other than GATED.

Reset
REQ-029 On rst: state=RUN, clk_en=1, wake_ack=0, gated=0, gate_events=0, counter=0. Takes effect on the next clk edge.
REQ-030 rst asserted in GATED or WAKE SHALL restore clk_en=1 on the next edge, without a WAKE settle period or wake_ack.

Structure
REQ-031 Package dma_cg_pkg SHALL hold the state enum (cg_state_t) and the default parameter values.
REQ-032 The idle counter (load/clear/increment/compare) SHALL be sub-module dma_cg_idle_cnt. The FSM, WAKE counter and event counter stay in dma_cg_ctrl.
REQ-033 The block SHALL NOT instantiate v_cg. The integrator connects clk_en to it; clk is the v_cg input clock.

Verification
REQ-034 Reset, then idle_thresh=3, cg_enable=1, busy=0 -> clk_en falls at cycle 4, gated=1, gate_events=1.
REQ-035 GATED, wake_req=1 at cycle T with WAKE_CYC=2 -> clk_en=1 at T+1, wake_ack pulse at T+3 only, state RUN.
REQ-036 idle_thresh=5 with busy pulsed at idle cycle 4 -> counter clears, no gating, gate_events unchanged.
REQ-037 GATED, test_mode=1 -> WAKE then RUN; clk_en stays 1 while test_mode is held; idle never re-gates.
REQ-038 gate_events forced to 16'hFFFF by 65535 gate cycles -> stays 16'hFFFF after a further gating.
REQ-039 rst asserted in WAKE -> next cycle: RUN, clk_en=1, wake_ack=0, gate_events=0.

Source files
------------

// File: rtl/dma_cg_pkg.sv
// ---------------------------------------------------------------------------
// dma_cg_pkg
// Shared types and default parameter values for the DMA clock-gate
// controller: the FSM state encoding and default widths and timing.
// ---------------------------------------------------------------------------
package dma_cg_pkg;

  localparam int DEF_IDLE_W   = 8;   // idle threshold / idle counter width
  localparam int DEF_WAKE_CYC = 2;   // settle cycles in WAKE (1..15)
  localparam int DEF_EVT_W    = 16;  // gate event counter width

  typedef enum logic [1:0] {
    CG_RUN      = 2'd0,
    CG_IDLE_CNT = 2'd1,
    CG_GATED    = 2'd2,
    CG_WAKE     = 2'd3
  } cg_state_t;

endpackage : dma_cg_pkg

// File: rtl/dma_cg_if.sv
// ---------------------------------------------------------------------------
// dma_cg_if
// Control/status bundle between a DMA channel and its clock-gate controller.
//   cg_enable, test_mode, busy, wake_req, idle_thresh : channel -> controller
//   clk_en, wake_ack, gated, gate_events              : controller -> channel
// master modport : the side driving requests (channel / testbench)
// slave  modport : dma_cg_ctrl
// ---------------------------------------------------------------------------
interface dma_cg_if
  import dma_cg_pkg::*;
#(
  parameter int IDLE_W = DEF_IDLE_W,
  parameter int EVT_W  = DEF_EVT_W
);

  logic              cg_enable;
  logic              test_mode;
  logic              busy;
  logic              wake_req;
  logic [IDLE_W-1:0] idle_thresh;
  logic              clk_en;
  logic              wake_ack;
  logic              gated;
  logic [EVT_W-1:0]  gate_events;

  modport master (
    output cg_enable, test_mode, busy, wake_req, idle_thresh,
    input  clk_en, wake_ack, gated, gate_events
  );

  modport slave (
    input  cg_enable, test_mode, busy, wake_req, idle_thresh,
    output clk_en, wake_ack, gated, gate_events
  );

endinterface : dma_cg_if

// File: rtl/dma_cg_idle_cnt.sv
// ---------------------------------------------------------------------------
// dma_cg_idle_cnt
// Consecutive-idle-cycle counter for the clock-gate controller.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : start a new idle run (counter <= 1)
//   inc_i     : another idle cycle (counter <= counter + 1, saturating)
//   thresh_i  : idle threshold
//   cnt_o     : current count
//   hit_o     : count has reached or passed the threshold
// With neither load_i nor inc_i the counter returns to 0, so every state
// that is not actively counting holds it cleared.
// ---------------------------------------------------------------------------
module dma_cg_idle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] thresh_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (load_i) begin
      cnt_d = {{(W-1){1'b0}}, 1'b1};
    end else if (inc_i) begin
      // Never wrap: an all-ones count is already >= any threshold.
      cnt_d = (cnt_q == {W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ">=" rather than "==": a threshold lowered below the running count
  // still gates on the next cycle instead of being missed.
  assign hit_o = (cnt_q >= thresh_i);
  assign cnt_o = cnt_q;

endmodule : dma_cg_idle_cnt

// File: rtl/dma_cg_ctrl.sv
// ---------------------------------------------------------------------------
// dma_cg_ctrl
// Automatic clock-gating controller for a DMA channel. Counts consecutive
// idle cycles, drops clk_en after the programmed threshold, and restores it
// on activity or an explicit wake request with a settle period before the
// request is acknowledged. clk_en feeds an external clock-gate cell whose
// input clock is this block's clk.
//   clk  : free-running clock
//   rst  : synchronous active-high reset
//   bus  : dma_cg_if.slave (inputs cg_enable, test_mode, busy, wake_req,
//          idle_thresh; outputs clk_en, wake_ack, gated, gate_events)
// ---------------------------------------------------------------------------
module dma_cg_ctrl
  import dma_cg_pkg::*;
#(
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int EVT_W    = DEF_EVT_W
) (
  input  logic     clk,
  input  logic     rst,
  dma_cg_if.slave  bus
);

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

  cg_state_t         state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [EVT_W-1:0]  evt_q, evt_d;
  logic              clk_en_q;
  logic              gated_q;
  logic              wake_ack_q, wake_ack_d;

  logic              idle;
  logic              wake_cond;
  logic              evt_inc;
  logic              cnt_load;
  logic              cnt_inc;
  logic              cnt_hit;
  logic [IDLE_W-1:0] cnt_val;

  assign idle = bus.cg_enable & ~bus.busy & ~bus.wake_req & ~bus.test_mode
              & (bus.idle_thresh != '0);

  assign wake_cond = bus.busy | bus.wake_req | ~bus.cg_enable | bus.test_mode;

  dma_cg_idle_cnt #(
    .W (IDLE_W)
  ) u_idle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cnt_load),
    .inc_i    (cnt_inc),
    .thresh_i (bus.idle_thresh),
    .cnt_o    (cnt_val),
    .hit_o    (cnt_hit)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = '0;
    wake_ack_d = 1'b0;
    evt_inc    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      CG_RUN: begin
        // The cycle right after an ack ignores wake_req so a requester
        // still holding it for one cycle gets exactly one pulse.
        wake_ack_d = bus.wake_req & ~wake_ack_q;
        if (idle) begin
          state_d  = CG_IDLE_CNT;
          cnt_load = 1'b1;
        end
      end
      CG_IDLE_CNT: begin
        wake_ack_d = bus.wake_req & ~wake_ack_q;
        if (!idle) begin
          state_d = CG_RUN;
        end else if (cnt_hit) begin
          state_d = CG_GATED;
          evt_inc = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      CG_GATED: begin
        if (wake_cond) begin
          state_d = CG_WAKE;
        end
      end
      CG_WAKE: begin
        if (bus.test_mode) begin
          state_d = CG_RUN;
        end else if (wcnt_q == WAKE_LAST) begin
          // A request dropped mid-settle finishes WAKE without an ack.
          state_d    = CG_RUN;
          wake_ack_d = bus.wake_req;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = CG_RUN;
      end
    endcase
  end

  assign evt_d = (evt_inc && (evt_q != {EVT_W{1'b1}})) ? evt_q + 1'b1 : evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CG_RUN;
      wcnt_q     <= '0;
      evt_q      <= '0;
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      evt_q      <= evt_d;
      // Outputs decoded from the next state so they align with state_q.
      clk_en_q   <= (state_d != CG_GATED);
      gated_q    <= (state_d == CG_GATED);
      wake_ack_q <= wake_ack_d;
    end
  end

  assign bus.clk_en      = clk_en_q;
  assign bus.gated       = gated_q;
  assign bus.wake_ack    = wake_ack_q;
  assign bus.gate_events = evt_q;

endmodule : dma_cg_ctrl

// File: tb/tb_dma_cg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_cg_ctrl
// Directed bench for dma_cg_ctrl. The event counter is built 6 bits wide
// so saturation is reachable in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_dma_cg_ctrl;
  import dma_cg_pkg::*;

  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;
  localparam int EVT_W    = 6;
  localparam logic [31:0] EVT_MAX = (32'd1 << EVT_W) - 32'd1;

  logic clk;
  logic rst;

  dma_cg_if #(.IDLE_W(IDLE_W), .EVT_W(EVT_W)) bus ();

  dma_cg_ctrl #(
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC),
    .EVT_W    (EVT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int timeouts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
      $display("chk %-14s ok   got=%0d", tag, obs);
    end else begin
      $display("FAIL %-14s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gated();
    int n = 0;
    while (!bus.gated && n < 20) begin
      tick();
      n++;
    end
    if (!bus.gated) timeouts++;
  endtask

  initial begin
    rst = 1'b1;
    bus.cg_enable   = 1'b0;
    bus.test_mode   = 1'b0;
    bus.busy        = 1'b0;
    bus.wake_req    = 1'b0;
    bus.idle_thresh = '0;
    tick();
    tick();
    chk("rst_clk_en", bus.clk_en, 1);
    chk("rst_gated", bus.gated, 0);
    chk("rst_wake_ack", bus.wake_ack, 0);
    chk("rst_events", bus.gate_events, 0);

    // Threshold 3, idle from cycle 0: clk_en low from cycle 4.
    bus.idle_thresh = 8'd3;
    bus.cg_enable   = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    chk("a_en_c3", bus.clk_en, 1);
    tick();
    chk("a_en_c4", bus.clk_en, 0);
    chk("a_gated_c4", bus.gated, 1);
    chk("a_events", bus.gate_events, 1);
    tick();
    chk("a_stay_gated", bus.clk_en, 0);

    // wake_req in GATED: clk_en at T+1, ack at T+3 only.
    bus.wake_req = 1'b1;
    tick();
    chk("b_en_t1", bus.clk_en, 1);
    chk("b_gated_t1", bus.gated, 0);
    chk("b_ack_t1", bus.wake_ack, 0);
    tick();
    chk("b_ack_t2", bus.wake_ack, 0);
    tick();
    chk("b_ack_t3", bus.wake_ack, 1);
    bus.wake_req  = 1'b0;
    bus.cg_enable = 1'b0;
    tick();
    chk("b_ack_t4", bus.wake_ack, 0);
    chk("b_en_t4", bus.clk_en, 1);

    // wake_req in RUN: ack next cycle; request held past ack gives one pulse.
    bus.wake_req = 1'b1;
    tick();
    chk("c_ack_run", bus.wake_ack, 1);
    bus.wake_req = 1'b0;
    tick();
    chk("c_ack_clr", bus.wake_ack, 0);
    bus.wake_req = 1'b1;
    tick();
    chk("c_ack_2", bus.wake_ack, 1);
    tick();
    chk("c_ack_ignored", bus.wake_ack, 0);
    bus.wake_req = 1'b0;
    tick();
    chk("c_ack_idle", bus.wake_ack, 0);

    // Threshold 5, busy at idle cycle 4: count restarts, gating at cycle 11.
    bus.idle_thresh = 8'd5;
    bus.cg_enable   = 1'b1;
    repeat (4) tick();
    bus.busy = 1'b1;
    tick();
    bus.busy = 1'b0;
    repeat (5) tick();
    chk("d_no_gate_c10", bus.clk_en, 1);
    chk("d_events_same", bus.gate_events, 1);
    tick();
    chk("d_gate_c11", bus.clk_en, 0);
    chk("d_events", bus.gate_events, 2);

    // test_mode in GATED: WAKE, then RUN held ungated.
    bus.test_mode = 1'b1;
    tick();
    chk("e_en_wake", bus.clk_en, 1);
    chk("e_gated_wake", bus.gated, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("e_en_hold%0d", i), bus.clk_en, 1);
    end
    chk("e_events", bus.gate_events, 2);
    chk("e_ack", bus.wake_ack, 0);
    bus.test_mode = 1'b0;
    bus.cg_enable = 1'b0;
    tick();

    // Threshold lowered below the running count: gate on the next cycle.
    bus.idle_thresh = 8'd10;
    bus.cg_enable   = 1'b1;
    repeat (6) tick();
    chk("f_en_c6", bus.clk_en, 1);
    bus.idle_thresh = 8'd3;
    tick();
    chk("f_gate_c7", bus.clk_en, 0);
    chk("f_events", bus.gate_events, 3);

    // busy and wake_req together in GATED: one WAKE, one ack.
    bus.busy     = 1'b1;
    bus.wake_req = 1'b1;
    tick();
    chk("g_en_t1", bus.clk_en, 1);
    chk("g_ack_t1", bus.wake_ack, 0);
    tick();
    chk("g_ack_t2", bus.wake_ack, 0);
    tick();
    chk("g_ack_t3", bus.wake_ack, 1);
    bus.busy      = 1'b0;
    bus.wake_req  = 1'b0;
    bus.cg_enable = 1'b0;
    tick();
    chk("g_ack_t4", bus.wake_ack, 0);

    // wake_req dropped during WAKE: WAKE completes, no ack.
    bus.idle_thresh = 8'd1;
    bus.cg_enable   = 1'b1;
    tick();
    tick();
    chk("h_gated", bus.gated, 1);
    chk("h_events", bus.gate_events, 4);
    bus.wake_req = 1'b1;
    tick();
    bus.wake_req = 1'b0;
    tick();
    chk("h_in_wake", bus.clk_en, 1);
    tick();
    chk("h_no_ack_t3", bus.wake_ack, 0);
    bus.cg_enable = 1'b0;
    tick();
    chk("h_no_ack_t4", bus.wake_ack, 0);

    // Reset during WAKE.
    bus.cg_enable = 1'b1;
    tick();
    tick();
    chk("i_gated", bus.gated, 1);
    chk("i_events", bus.gate_events, 5);
    bus.busy = 1'b1;
    tick();
    rst = 1'b1;
    bus.busy = 1'b0;
    tick();
    chk("i_rst_en", bus.clk_en, 1);
    chk("i_rst_gated", bus.gated, 0);
    chk("i_rst_ack", bus.wake_ack, 0);
    chk("i_rst_events", bus.gate_events, 0);
    rst = 1'b0;
    bus.cg_enable = 1'b0;
    tick();
    chk("i_post_ack", bus.wake_ack, 0);
    chk("i_post_en", bus.clk_en, 1);

    // Reset while GATED restores clk_en immediately.
    bus.cg_enable = 1'b1;
    tick();
    tick();
    chk("j_gated", bus.gated, 1);
    rst = 1'b1;
    tick();
    chk("j_rst_en", bus.clk_en, 1);
    chk("j_rst_gated", bus.gated, 0);
    rst = 1'b0;

    // Saturation of the event counter.
    for (int i = 0; i < int'(EVT_MAX); i++) begin
      wait_gated();
      bus.busy = 1'b1;
      tick();
      bus.busy = 1'b0;
    end
    chk("k_events_max", bus.gate_events, EVT_MAX);
    wait_gated();
    chk("k_gated_more", bus.gated, 1);
    chk("k_events_sat", bus.gate_events, EVT_MAX);
    chk("k_timeouts", timeouts, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_dma_cg_ctrl
